// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: LANES MACs per cycle over a latched activation vector.
// Optional FC_RELU_EN clamps negative results to zero before they are registered.
module fc_layer_seq #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int INPUT_NODES  = 120,
  parameter int OUTPUT_NODES = 1200,
  parameter int LANES        = 8,
  parameter int ACC_WIDTH    = 40,
  parameter int IDX_W        = (OUTPUT_NODES > 1) ? $clog2(OUTPUT_NODES) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [DATA_WIDTH*INPUT_NODES-1:0] input_fc,
  output logic                              busy,
  output logic                              done,
  input  logic                              w_valid,
  output logic                              w_ready,
  input  logic [DATA_WIDTH*LANES-1:0]       w_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic [IDX_W-1:0]                  out_index,
  output logic [1:0]                        state_dbg
);

  // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
  // the source holds data stable while valid is high and ready is low.

  localparam int BEATS = INPUT_NODES / LANES;
  localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [K_W-1:0]   K_LAST = K_W'(BEATS - 1);
  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(OUTPUT_NODES - 1);

  localparam logic signed [ACC_WIDTH-1:0] ROUND_C   = ACC_WIDTH'(longint'(1) << (FRAC_BITS - 1));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX_A =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN_A =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MAX_W = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN_W = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

  state_t                              state;
  logic [DATA_WIDTH*INPUT_NODES-1:0]   act_q;
  logic signed [ACC_WIDTH-1:0]         acc;
  logic [K_W-1:0]                      k;
  logic [IDX_W-1:0]                    j;

  logic signed [2*DATA_WIDTH-1:0]      prod;
  logic signed [ACC_WIDTH-1:0]         beat_sum;
  logic signed [ACC_WIDTH-1:0]         acc_sum;
  logic signed [ACC_WIDTH-1:0]         rounded;
  logic [DATA_WIDTH-1:0]               res;

  assign state_dbg = state;

  always_comb begin
    prod     = '0;
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      prod = $signed(act_q[DATA_WIDTH*(int'(k)*LANES + l) +: DATA_WIDTH]) *
             $signed(w_data[DATA_WIDTH*l +: DATA_WIDTH]);
      beat_sum = beat_sum + ACC_WIDTH'(prod);
    end
    acc_sum = acc + beat_sum;
    // Round half up, then arithmetic shift back to the word's fixed-point scale.
    rounded = (acc_sum + ROUND_C) >>> FRAC_BITS;
    if (rounded > SAT_MAX_A)      res = SAT_MAX_W;
    else if (rounded < SAT_MIN_A) res = SAT_MIN_W;
    else                          res = rounded[DATA_WIDTH-1:0];
`ifdef FC_RELU_EN
    if (res[DATA_WIDTH-1]) res = '0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      act_q     <= '0;
      acc       <= '0;
      k         <= '0;
      j         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      w_ready   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            act_q   <= input_fc;
            acc     <= '0;
            k       <= '0;
            j       <= '0;
            busy    <= 1'b1;
            w_ready <= 1'b1;
            state   <= S_MAC;
          end
        end
        S_MAC: begin
          if (w_valid && w_ready) begin
            acc <= acc_sum;
            if (k == K_LAST) begin
              k         <= '0;
              out_data  <= res;
              out_index <= j;
              out_valid <= 1'b1;
              w_ready   <= 1'b0;
              state     <= S_OUT;
            end else begin
              k <= k + K_W'(1);
            end
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (j == J_LAST) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              j       <= j + IDX_W'(1);
              acc     <= '0;
              w_ready <= 1'b1;
              state   <= S_MAC;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq: small layer (4 inputs, 2 lanes, 2 outputs) against an arithmetic model.
module tb_fc_layer_seq;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int IN = 4;
  localparam int LN = 2;
  localparam int ON = 2;
  localparam int AW = 40;
  localparam int BPN = IN / LN;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [DW*IN-1:0]  input_fc;
  logic              busy, done;
  logic              w_valid, w_ready;
  logic [DW*LN-1:0]  w_data;
  logic              out_valid, out_ready;
  logic [DW-1:0]     out_data;
  logic [0:0]        out_index;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] act[IN];
  logic [DW-1:0] wts[ON][IN];
  logic [DW-1:0] exp_q[$];
  int            exp_idx_q[$];

  fc_layer_seq #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .INPUT_NODES(IN),
    .OUTPUT_NODES(ON), .LANES(LN), .ACC_WIDTH(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .input_fc(input_fc),
    .busy(busy), .done(done), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: dot product, round half up, saturate
  function automatic logic [DW-1:0] model_node(int n);
    longint s = 0;
    longint r;
    logic [DW-1:0] v;
    for (int i = 0; i < IN; i++)
      s += longint'($signed(act[i])) * longint'($signed(wts[n][i]));
    r = (s + (longint'(1) << (FB - 1))) >>> FB;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`ifdef FC_RELU_EN
    if (r < 0) r = 0;
`endif
    v = r[DW-1:0];
    return v;
  endfunction

  function automatic logic [DW*IN-1:0] pack_act();
    logic [DW*IN-1:0] v;
    for (int i = 0; i < IN; i++) v[DW*i +: DW] = act[i];
    return v;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    if ($urandom_range(0, 3) == 0) return DW'($urandom);
    return DW'($urandom_range(0, 2047) - 1024);
  endfunction

  task automatic fill_all(input logic [DW-1:0] a, input logic [DW-1:0] w);
    for (int i = 0; i < IN; i++) act[i] = a;
    for (int n = 0; n < ON; n++)
      for (int i = 0; i < IN; i++) wts[n][i] = w;
  endtask

  task automatic fill_random();
    for (int i = 0; i < IN; i++) act[i] = rand_word();
    for (int n = 0; n < ON; n++)
      for (int i = 0; i < IN; i++) wts[n][i] = rand_word();
  endtask

  // driver: one full run with optional valid gaps, output stalls and spurious starts
  task automatic run_layer(input bit gaps, input int stall, input bit spurious, output int cycles);
    int beat;
    int stall_left;
    bit holding;
    bit got_done;
    logic [DW-1:0] held_d;
    logic [0:0] held_i;
    logic [DW-1:0] ed;
    int ei;
    for (int n = 0; n < ON; n++) begin
      exp_q.push_back(model_node(n));
      exp_idx_q.push_back(n);
    end
    @(negedge clk);
    input_fc  = pack_act();
    start     = 1'b1;
    w_valid   = 1'b0;
    out_ready = (stall == 0);
    cycles = 1; beat = 0; stall_left = stall; holding = 0; got_done = 0;
    held_d = '0; held_i = '0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (t == 0) begin
        input_fc = {$urandom, $urandom};
        checks++;
        if (busy !== 1'b1 || w_ready !== 1'b1) begin
          errors++;
          $display("FAIL run_entry: busy=%b w_ready=%b, required 1 1", busy, w_ready);
        end
      end
      if (done) begin
        got_done = 1;
        break;
      end
      if (spurious && busy && $urandom_range(0, 2) == 0) start = 1'b1;
      if (beat < BPN * ON) begin
        w_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        for (int l = 0; l < LN; l++)
          w_data[DW*l +: DW] = wts[beat / BPN][(beat % BPN) * LN + l];
        if (w_valid && w_ready) beat++;
      end else begin
        w_valid = gaps ? 1'(($urandom_range(0, 1))) : 1'b0;
      end
      if (out_valid) begin
        checks++;
        if (w_ready !== 1'b0) begin
          errors++;
          $display("FAIL out_wready: w_ready=%b in OUT, required 0", w_ready);
        end
        if (!holding) begin
          holding = 1; held_d = out_data; held_i = out_index; stall_left = stall;
        end else begin
          checks++;
          if (out_data !== held_d || out_index !== held_i) begin
            errors++;
            $display("FAIL out_stable: data=%h idx=%0d, required %h %0d",
                     out_data, out_index, held_d, held_i);
          end
        end
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          holding = 0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_extra: data=%h idx=%0d, required no output", out_data, out_index);
          end else begin
            ed = exp_q.pop_front();
            ei = exp_idx_q.pop_front();
            if (out_data !== ed || out_index !== 1'(ei)) begin
              errors++;
              $display("FAIL out_value: data=%h idx=%0d, required %h %0d",
                       out_data, out_index, ed, ei);
            end
          end
        end
      end else begin
        out_ready = (stall == 0);
      end
    end
    w_valid = 1'b0;
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL run_timeout: no done within 300 cycles, beats=%0d", beat);
    end else begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL done_busy: busy=%b with done, required 0", busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse: done=%b second cycle, required 0", done);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_out: %0d outputs not seen, required 0", exp_q.size());
    end
    exp_q.delete();
    exp_idx_q.delete();
    out_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (busy !== 0 || done !== 0 || w_ready !== 0 || out_valid !== 0 ||
        out_data !== '0 || out_index !== '0) begin
      errors++;
      $display("FAIL %s: busy=%b done=%b w_ready=%b out_valid=%b data=%h idx=%0d, required all 0",
               name, busy, done, w_ready, out_valid, out_data, out_index);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; w_valid = 1'b0; out_ready = 1'b0;
    input_fc = '0; w_data = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_hold");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_release");
  endtask

  task automatic test_basic();
    int cyc;
    fill_all(16'h0100, 16'h0080);
    run_layer(0, 0, 0, cyc);
    checks++;
    if (cyc != 8) begin
      errors++;
      $display("FAIL basic_latency: %0d cycles start-to-done, required 8", cyc);
    end
  endtask

  task automatic test_saturation();
    int cyc;
    fill_all(16'h7FFF, 16'h7FFF);
    run_layer(0, 0, 0, cyc);
    fill_all(16'h7FFF, 16'h8000);
    run_layer(0, 0, 0, cyc);
  endtask

  task automatic test_rounding();
    int cyc;
    fill_all(16'h0001, 16'h0000);
    wts[0][0] = 16'h0080;
    wts[1][2] = 16'h007F;
    run_layer(0, 0, 0, cyc);
    fill_all(16'h0001, 16'h0000);
    wts[0][3] = 16'hFF80;
    wts[1][1] = 16'h0180;
    run_layer(0, 0, 0, cyc);
  endtask

  task automatic test_negative();
    int cyc;
    fill_all(16'h0100, 16'hFF80);
    run_layer(0, 0, 0, cyc);
  endtask

  task automatic test_gaps_stall();
    int cyc;
    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_layer(1, 5, 0, cyc);
    end
  endtask

  task automatic test_random();
    int cyc;
    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_layer(0, 0, 0, cyc);
      checks++;
      if (cyc != 8) begin
        errors++;
        $display("FAIL random_latency: %0d cycles, required 8", cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    fill_all(16'h0100, 16'h0080);
    @(negedge clk);
    input_fc  = pack_act();
    start     = 1'b1;
    w_valid   = 1'b1;
    for (int l = 0; l < LN; l++) w_data[DW*l +: DW] = 16'h0080;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 reset = 1'b0;
    #1 check_idle_outputs("reset_mid");
    w_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid_idle");
    run_layer(0, 0, 0, cyc);
  endtask

  task automatic test_start_while_busy();
    int cyc;
    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_layer(r == 1, (r == 2) ? 3 : 0, 1, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_negative();
    test_gaps_stall();
    test_random();
    test_reset_mid();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_layer_seq.md
# fc_layer_seq

Sequential fully-connected layer engine: computes OUTPUT_NODES dot products of one latched INPUT_NODES activation vector against a streamed weight matrix, LANES multiply-accumulates per cycle. Signed fixed-point throughout. Sits between the activation buffer and the next layer; weights come from an external weight memory/DMA stream and results leave on a ready/valid stream, one output node per beat.

## Interface

- DATA_WIDTH, 16, signed fixed-point word width (activations, weights, outputs)
- FRAC_BITS, 8, fractional bits of every word (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS)
- INPUT_NODES, 120, input vector length; must be a multiple of LANES
- OUTPUT_NODES, 1200, number of output nodes produced per run
- LANES, 8, MACs per cycle (weights per beat)
- ACC_WIDTH, 40, signed accumulator width; must be ≥ 2*DATA_WIDTH + clog2(INPUT_NODES)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- input_fc  in  DATA_WIDTH*INPUT_NODES  activation vector, node i at [DATA_WIDTH*i +: DATA_WIDTH]; latched on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of run
- w_valid  in  1  weight beat valid
- w_ready  out  1  engine accepts weight beat
- w_data  in  DATA_WIDTH*LANES  weight beat, lane l at [DATA_WIDTH*l +: DATA_WIDTH]
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts output
- out_data  out  DATA_WIDTH  rounded/saturated output value
- out_index  out  clog2(OUTPUT_NODES)  output node number of out_data

## Operation

- FSM states: IDLE, MAC, OUT, DONE.
- IDLE: start=1 → latch input_fc, clear accumulator, beat counter k=0, node counter j=0, busy=1 → MAC. start outside IDLE ignored.
- MAC: w_ready=1. Per handshake (w_valid&w_ready): acc += Σ_l input[k*LANES+l]*w_data[l]; products signed 2*DATA_WIDTH, sign-extended to ACC_WIDTH. No handshake → acc, k unchanged. Handshake on k=INPUT_NODES/LANES-1 → register result into out_data, out_index=j → OUT.
- Beat order: beat k of node j holds weights W[j][k*LANES .. k*LANES+LANES-1]; node-major, no gaps between nodes.
- Result: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half up), saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- OUT: out_valid=1, w_ready=0; out_data/out_index held stable until out_ready. Handshake: j==OUTPUT_NODES-1 → DONE; else j++, k=0, acc=0 → MAC.
- DONE: done=1 for one cycle, busy=0 → IDLE.
- reset low (any state, asynchronous): state=IDLE, all counters/acc/latched vector cleared, outputs to reset values. Partial run discarded.

## Timing

- Reset values: busy=0, done=0, w_ready=0, out_valid=0, out_data=0, out_index=0.
- busy rises cycle after accepted start; w_ready high same cycle as MAC entry.
- Last beat of a node accepted at edge N → out_valid high after edge N (one-cycle result latency).
- Minimum cycles per node: INPUT_NODES/LANES + 1; per run: OUTPUT_NODES*(INPUT_NODES/LANES+1) + 2.
- out_ready asserted before out_valid is legal; handshake completes on the first cycle both high.
- done one cycle after final output handshake; start accepted again the following cycle.
- w_valid with w_ready=0 has no effect; source must hold w_data until handshake.

## Configuration

- FC_RELU_EN defined: saturated result r replaced by 0 when negative before out_data register.
- FC_RELU_EN undefined: out_data is signed saturated r unmodified.

## Test plan

Bench params: INPUT_NODES=4, LANES=2, OUTPUT_NODES=2, FRAC_BITS=8, DATA_WIDTH=16.
- Inputs all 0x0100 (1.0), weights all 0x0080 (0.5), continuous valid/ready → out_data 0x0200 idx 0, then 0x0200 idx 1, done one pulse, total 8 cycles start-to-done.
- Inputs all 0x7FFF, weights 0x7FFF → 0x7FFF; weights 0x8000 → 0x8000 (saturation both ends); inputs 0x0001, weights 0x0080, one nonzero lane → 0x0001 (rounding).
- Random w_valid gaps, out_ready held low 5 cycles in OUT → out_data/out_index stable, w_ready=0, results equal gap-free run.
- reset pulsed low mid-MAC → all outputs 0 immediately; new run with test-1 stimulus yields 0x0200, 0x0200.
- Inputs 0x0100, weights 0xFF80 (-0.5) → 0xFE00 without FC_RELU_EN, 0x0000 with it.
- start pulsed while busy → ignored; out_index sequence 0,1 and single done unchanged.
